// File: rtl/tick_pkg.sv
// Shared types and constants for the tick generator and its downstream consumers.
package tick_pkg;

  // Clocks between consecutive DELAY tick pulses (DELAY N+1).
  localparam int unsigned DEFAULT_PERIOD = 50001;

  typedef enum logic [1:0] {
    WD_IDLE,
    WD_ARMED,
    WD_WARN,
    WD_BITE
  } wd_state_t;

endpackage

// File: rtl/tick_period_chk.sv
// Tick periodicity checker: counts clocks between ticks and raises a sticky fault
// on an early, late or missing tick, or on a DELAY overrun error.
module tick_period_chk
  import tick_pkg::*;
#(
  parameter int unsigned PERIOD = DEFAULT_PERIOD,
  parameter int unsigned GBITS  = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic tick_err,
  output logic fault
);

  localparam logic [GBITS-1:0] GapMax  = {GBITS{1'b1}};
  localparam logic [GBITS:0]   PeriodW = (GBITS+1)'(PERIOD);

  logic [GBITS-1:0] gap_q, gap_d;
  logic [GBITS:0]   gap_inc;
  logic             seen_q, seen_d;
  logic             fault_q, fault_d;

  always_comb begin
    // One bit wider so a saturated gap still compares correctly against PERIOD.
    gap_inc = {1'b0, gap_q} + 1'b1;
    seen_d  = seen_q | tick;
    if (tick) begin
      gap_d = '0;
    end else if (gap_q == GapMax) begin
      gap_d = gap_q;
    end else begin
      gap_d = gap_q + 1'b1;
    end
    fault_d = fault_q | tick_err
            | (seen_q & tick & (gap_inc != PeriodW))
            | (seen_q & ~tick & (gap_inc > PeriodW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q   <= '0;
      seen_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      seen_q  <= seen_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/tick_watchdog.sv
// Tick-counted watchdog with warn/bite outputs, plus a tick period checker whose
// sticky fault flag goes to the system supervisor.
module tick_watchdog
  import tick_pkg::*;
#(
  parameter int unsigned PERIOD     = DEFAULT_PERIOD,
  parameter int unsigned GBITS      = 17,
  parameter int unsigned WARN_TICKS = 3,
  parameter int unsigned BITE_TICKS = 5,
  parameter int unsigned TBITS      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             tick_err,
  input  logic             enable,
  input  logic             kick,
  output logic             warn,
  output logic             bite,
  output logic             fault,
  output logic [TBITS-1:0] tick_cnt
);

  localparam logic [TBITS-1:0] WarnCnt = TBITS'(WARN_TICKS);
  localparam logic [TBITS-1:0] BiteCnt = TBITS'(BITE_TICKS);

  wd_state_t        state_q, state_d;
  logic [TBITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic             warn_q, bite_q;

  tick_period_chk #(
    .PERIOD (PERIOD),
    .GBITS  (GBITS)
  ) u_period_chk (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .tick_err (tick_err),
    .fault    (fault)
  );

  always_comb begin
    cnt_inc = (cnt_q == {TBITS{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WD_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = WD_ARMED;
      end
      WD_ARMED, WD_WARN: begin
        // Disarm takes priority over kick, and kick over tick.
        if (!enable) begin
          state_d = WD_IDLE;
          cnt_d   = '0;
        end else if (kick) begin
          state_d = WD_ARMED;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (state_q == WD_ARMED && cnt_inc == WarnCnt) state_d = WD_WARN;
          if (state_q == WD_WARN && cnt_inc == BiteCnt) state_d = WD_BITE;
        end
      end
      WD_BITE: ;
      default: begin
        state_d = WD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WD_IDLE;
      cnt_q   <= '0;
      warn_q  <= 1'b0;
      bite_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warn_q  <= (state_d == WD_WARN);
      bite_q  <= (state_d == WD_BITE);
    end
  end

  assign warn     = warn_q;
  assign bite     = bite_q;
  assign tick_cnt = cnt_q;

endmodule

// File: tb/tb_tick_watchdog.sv
// Directed bench for tick_watchdog with a short tick period.
module tb_tick_watchdog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       tick_err = 1'b0;
  logic       enable = 1'b0;
  logic       kick = 1'b0;
  logic       warn, bite, fault;
  logic [7:0] tick_cnt;

  int total = 0;
  int bad   = 0;

  tick_watchdog #(
    .PERIOD     (8),
    .GBITS      (4),
    .WARN_TICKS (3),
    .BITE_TICKS (5),
    .TBITS      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .tick_err (tick_err),
    .enable   (enable),
    .kick     (kick),
    .warn     (warn),
    .bite     (bite),
    .fault    (fault),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic t, input logic k);
    tick = t;
    kick = k;
    @(posedge clk);
    #1;
    tick = 1'b0;
    kick = 1'b0;
  endtask

  // Seven quiet cycles then a tick: keeps an 8-clock period.
  task automatic period(input logic k);
    repeat (7) cyc(1'b0, 1'b0);
    cyc(1'b1, k);
  endtask

  task automatic check_all(input string tag, input logic w, input logic b, input logic f,
                           input logic [7:0] c);
    check_val({tag, ".warn"}, 32'(warn), 32'(w));
    check_val({tag, ".bite"}, 32'(bite), 32'(b));
    check_val({tag, ".fault"}, 32'(fault), 32'(f));
    check_val({tag, ".cnt"}, 32'(tick_cnt), 32'(c));
  endtask

  initial begin
    // Reset state
    repeat (2) cyc(1'b0, 1'b0);
    check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    // 1: periodic ticks, watchdog disabled
    cyc(1'b1, 1'b0);
    period(1'b0);
    period(1'b0);
    check_all("t1_idle", 1'b0, 1'b0, 1'b0, 8'd0);

    // 2: armed, no kick -> warn at 3, bite at 5
    enable = 1'b1;
    period(1'b0);
    check_all("t2_tick1", 1'b0, 1'b0, 1'b0, 8'd1);
    period(1'b0);
    period(1'b0);
    check_all("t2_warn", 1'b1, 1'b0, 1'b0, 8'd3);
    period(1'b0);
    check_all("t2_tick4", 1'b1, 1'b0, 1'b0, 8'd4);
    period(1'b0);
    check_all("t2_bite", 1'b0, 1'b1, 1'b0, 8'd5);
    enable = 1'b0;
    cyc(1'b0, 1'b1);
    repeat (6) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check_all("t2_sticky", 1'b0, 1'b1, 1'b0, 8'd5);

    // 6b: reset while in BITE
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    check_all("t6_rst_bite", 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    // 3: kick coincident with a tick
    enable = 1'b1;
    cyc(1'b1, 1'b0);
    check_val("t3_arm_cnt", 32'(tick_cnt), 32'd0);
    period(1'b0);
    check_val("t3_cnt1", 32'(tick_cnt), 32'd1);
    period(1'b1);
    check_all("t3_kick", 1'b0, 1'b0, 1'b0, 8'd0);
    check_val("t3_state", 32'(dut.state_q), 32'(tick_pkg::WD_ARMED));

    // 4: drop enable while in WARN
    period(1'b0);
    period(1'b0);
    period(1'b0);
    check_all("t4_warn", 1'b1, 1'b0, 1'b0, 8'd3);
    enable = 1'b0;
    cyc(1'b0, 1'b0);
    check_all("t4_idle", 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (6) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);

    // 5a: gaps 8, 8, then 6
    period(1'b0);
    period(1'b0);
    check_val("t5_ok", 32'(fault), 32'd0);
    repeat (5) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check_val("t5_early", 32'(fault), 32'd1);
    repeat (10) cyc(1'b0, 1'b0);
    check_val("t5_sticky", 32'(fault), 32'd1);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    check_val("t5_rst", 32'(fault), 32'd0);

    // 5b: tick stops
    cyc(1'b1, 1'b0);
    repeat (8) cyc(1'b0, 1'b0);
    check_val("t5_miss_pre", 32'(fault), 32'd0);
    cyc(1'b0, 1'b0);
    check_val("t5_miss", 32'(fault), 32'd1);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;

    // 6a: tick_err pulse
    check_val("t6_pre", 32'(fault), 32'd0);
    tick_err = 1'b1;
    cyc(1'b0, 1'b0);
    tick_err = 1'b0;
    check_val("t6_err", 32'(fault), 32'd1);
    cyc(1'b0, 1'b0);
    check_val("t6_err_sticky", 32'(fault), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
